// File: rtl/intsched.sv
// intsched: round-robin arbiter that shares one intctl bus-request level among
// NREQ interrupting devices. Offers one pending vector at a time, holds it until
// intctl signals the transfer, acks the device and drains before re-arbitrating.
module intsched #(
  parameter int unsigned NREQ = 4
) (
  input  logic              CLOCK,
  input  logic              RESET,
  input  logic              init_in_h,
  input  logic [NREQ-1:0]   req_h,
  input  logic [8*NREQ-1:0] vec_in,
  input  logic              sack_out_h,
  input  logic              intr_out_h,
  input  logic              bbsy_out_h,
  output logic [7:0]        intvec,
  output logic [NREQ-1:0]   ack_h,
  output logic              busy_h,
  output logic [2:0]        sel
);

  localparam int unsigned     IW      = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [NREQ-1:0] OneHot  = NREQ'(1);
  localparam logic [7:0]      NoReq   = 8'h01;
  localparam logic [2:0]      PtrInit = 3'(NREQ - 1);

  typedef enum logic [1:0] {StIdle, StOffer, StDrain} state_e;

  state_e          r_state, w_state_d;
  logic [7:0]      r_intvec, w_intvec_d;
  logic [NREQ-1:0] r_ack, w_ack_d;
  logic [2:0]      r_sel, w_sel_d;
  logic [2:0]      r_ptr, w_ptr_d;
  logic            r_dmin, w_dmin_d;
  logic            r_busy;

  logic [NREQ-1:0] w_elig;
  logic            w_any;
  logic [2:0]      w_win;
  logic [7:0]      w_win_vec;
  logic            w_req_sel;
  logic            w_bus_quiet;

  // Eligibility: requesting and not masked by vector bit 0.
  always_comb begin
    w_elig = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      w_elig[i] = req_h[i] & ~vec_in[8*i];
    end
  end

  // Rotating search from ptr+1; scanning backwards lets the nearest hit win.
  always_comb begin
    w_any = 1'b0;
    w_win = r_ptr;
    for (int k = int'(NREQ); k >= 1; k--) begin
      logic [3:0] idx;
      idx = {1'b0, r_ptr} + 4'(k);
      if (idx >= 4'(NREQ)) idx = idx - 4'(NREQ);
      if (w_elig[idx[IW-1:0]]) begin
        w_any = 1'b1;
        w_win = idx[2:0];
      end
    end
  end

  // Winner's vector with bit 1 forced low (bit 0 is known clear for an eligible winner).
  always_comb begin
    w_win_vec   = 8'(vec_in >> {w_win, 3'b000}) & 8'hFC;
    w_req_sel   = |(req_h & (OneHot << r_sel));
    w_bus_quiet = ~intr_out_h & ~bbsy_out_h & ~sack_out_h;
  end

  // State register.
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) r_state <= StIdle;
    else        r_state <= w_state_d;
  end

  // Next-state logic; INIT behaves as a synchronous clear.
  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:  if (w_any) w_state_d = StOffer;
      StOffer: if (intr_out_h || !w_req_sel) w_state_d = StDrain;
      StDrain: if (r_dmin && w_bus_quiet) w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
    if (init_in_h) w_state_d = StIdle;
  end

  // Next values for the registered outputs, pointer and drain-minimum flag.
  always_comb begin
    w_intvec_d = r_intvec;
    w_ack_d    = '0;
    w_sel_d    = r_sel;
    w_ptr_d    = r_ptr;
    w_dmin_d   = r_dmin;
    unique case (r_state)
      StIdle: begin
        w_intvec_d = NoReq;
        w_dmin_d   = 1'b0;
        if (w_any) begin
          w_sel_d    = w_win;
          w_intvec_d = w_win_vec;
        end
      end
      StOffer: begin
        // intr wins over a same-cycle withdrawal: the transfer already happened.
        if (intr_out_h) begin
          w_intvec_d = NoReq;
          w_ack_d    = OneHot << r_sel;
          w_ptr_d    = r_sel;
          w_dmin_d   = 1'b0;
        end else if (!w_req_sel) begin
          w_intvec_d = NoReq;
          w_dmin_d   = 1'b0;
        end
      end
      StDrain: begin
        // First DRAIN cycle only arms the flag, giving a two-cycle minimum.
        w_intvec_d = NoReq;
        w_dmin_d   = 1'b1;
      end
      default: w_intvec_d = NoReq;
    endcase
    if (init_in_h) begin
      w_intvec_d = NoReq;
      w_ack_d    = '0;
      w_sel_d    = 3'd0;
      w_ptr_d    = PtrInit;
      w_dmin_d   = 1'b0;
    end
  end

  // Output and datapath registers.
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      r_intvec <= NoReq;
      r_ack    <= '0;
      r_sel    <= 3'd0;
      r_ptr    <= PtrInit;
      r_dmin   <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_intvec <= w_intvec_d;
      r_ack    <= w_ack_d;
      r_sel    <= w_sel_d;
      r_ptr    <= w_ptr_d;
      r_dmin   <= w_dmin_d;
      r_busy   <= (w_state_d != StIdle);
    end
  end

  assign intvec = r_intvec;
  assign ack_h  = r_ack;
  assign busy_h = r_busy;
  assign sel    = r_sel;

endmodule

// File: tb/tb_intsched.sv
// Directed bench for intsched with NREQ=4; intctl handshakes are driven by hand.
module tb_intsched;

  localparam int N = 4;

  logic           CLOCK = 1'b0;
  logic           RESET = 1'b1;
  logic           init_in_h = 1'b0;
  logic [N-1:0]   req_h = '0;
  logic [7:0]     v [N];
  logic [8*N-1:0] vec_in;
  logic           sack_out_h = 1'b0;
  logic           intr_out_h = 1'b0;
  logic           bbsy_out_h = 1'b0;
  logic [7:0]     intvec;
  logic [N-1:0]   ack_h;
  logic           busy_h;
  logic [2:0]     sel;

  int n_checks = 0;
  int n_fail   = 0;

  assign vec_in = {v[3], v[2], v[1], v[0]};

  always #5 CLOCK = ~CLOCK;

  intsched #(.NREQ(N)) dut (
    .CLOCK      (CLOCK),
    .RESET      (RESET),
    .init_in_h  (init_in_h),
    .req_h      (req_h),
    .vec_in     (vec_in),
    .sack_out_h (sack_out_h),
    .intr_out_h (intr_out_h),
    .bbsy_out_h (bbsy_out_h),
    .intvec     (intvec),
    .ack_h      (ack_h),
    .busy_h     (busy_h),
    .sel        (sel)
  );

  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for an offer and checks it belongs to device idx.
  task automatic wait_offer(input logic [1:0] idx);
    bit seen;
    logic [7:0] ev;
    seen = 1'b0;
    for (int t = 0; t < 12; t++) begin
      if (!seen) begin
        tick();
        if (intvec !== 8'h01) seen = 1'b1;
      end
    end
    ev = {v[idx][7:2], 2'b00};
    chk("offer_seen", 32'(seen), 32'd1);
    chk("offer_sel", 32'(sel), 32'(idx));
    chk("offer_vec", 32'(intvec), 32'(ev));
    chk("offer_busy", 32'(busy_h), 32'd1);
  endtask

  // intctl transfers the vector; optionally the device withdraws in the same cycle.
  task automatic complete(input logic [1:0] idx, input bit withdraw_too);
    logic [3:0] ea;
    ea = 4'b0001 << idx;
    sack_out_h = 1'b1;
    intr_out_h = 1'b1;
    bbsy_out_h = 1'b1;
    if (withdraw_too) req_h[idx] = 1'b0;
    tick();
    chk("ack_pulse", 32'(ack_h), 32'(ea));
    chk("ack_intvec", 32'(intvec), 32'h01);
    req_h[idx] = 1'b0;
    intr_out_h = 1'b0;
    sack_out_h = 1'b0;
    bbsy_out_h = 1'b0;
    tick();
    chk("ack_single", 32'(ack_h), 32'd0);
  endtask

  task automatic serve(input logic [1:0] idx);
    wait_offer(idx);
    complete(idx, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < N; i++) v[i] = 8'h01;

    // Reset state
    #1 RESET = 1'b0;
    #2;
    chk("rst_intvec", 32'(intvec), 32'h01);
    chk("rst_busy", 32'(busy_h), 32'd0);
    chk("rst_ack", 32'(ack_h), 32'd0);
    chk("rst_sel", 32'(sel), 32'd0);
    #10 RESET = 1'b1;
    tick();

    // Single device 2, vector 0304 octal
    v[2]  = 8'o304;
    req_h = 4'b0100;
    tick();
    chk("single_vec", 32'(intvec), 32'hC4);
    chk("single_busy", 32'(busy_h), 32'd1);
    chk("single_sel", 32'(sel), 32'd2);
    repeat (4) tick();
    sack_out_h = 1'b1;
    tick();
    chk("single_hold", 32'(intvec), 32'hC4);
    intr_out_h = 1'b1;
    bbsy_out_h = 1'b1;
    tick();
    chk("single_ack", 32'(ack_h), 32'b0100);
    chk("single_clr", 32'(intvec), 32'h01);
    req_h      = 4'b0000;
    intr_out_h = 1'b0;
    sack_out_h = 1'b0;
    tick();
    chk("single_ack1", 32'(ack_h), 32'd0);
    tick();
    chk("single_drain_bbsy", 32'(busy_h), 32'd1);
    bbsy_out_h = 1'b0;
    tick();
    chk("single_idle", 32'(busy_h), 32'd0);
    chk("single_idle_vec", 32'(intvec), 32'h01);

    // Rotation after a fresh reset: 0,1,2,3 then 0 ahead of pending 1
    RESET = 1'b0;
    #2 RESET = 1'b1;
    v[0] = 8'h10; v[1] = 8'h20; v[2] = 8'h30; v[3] = 8'h40;
    req_h = 4'b1111;
    serve(2'd0);
    serve(2'd1);
    req_h[0] = 1'b1;
    serve(2'd2);
    req_h[1] = 1'b1;
    serve(2'd3);
    serve(2'd0);

    // Withdrawal of device 1; device 2 comes next
    wait_offer(2'd1);
    req_h = 4'b0100;
    tick();
    chk("wd_clr", 32'(intvec), 32'h01);
    chk("wd_noack", 32'(ack_h), 32'd0);
    tick();
    chk("wd_noack2", 32'(ack_h), 32'd0);

    // Device 2 offered; withdraws in the same cycle intctl raises intr
    wait_offer(2'd2);
    complete(2'd2, 1'b1);

    // Masking and bit 1
    v[0]  = 8'h41;
    v[1]  = 8'h42;
    req_h = 4'b0011;
    wait_offer(2'd1);
    chk("mask_vec", 32'(intvec), 32'h40);
    complete(2'd1, 1'b0);
    repeat (6) tick();
    chk("mask_idle", 32'(busy_h), 32'd0);
    chk("mask_vec01", 32'(intvec), 32'h01);

    // Asynchronous reset mid-offer
    v[0]  = 8'h10;
    req_h = 4'b0100;
    wait_offer(2'd2);
    #2 RESET = 1'b0;
    #1;
    chk("arst_intvec", 32'(intvec), 32'h01);
    chk("arst_busy", 32'(busy_h), 32'd0);
    chk("arst_sel", 32'(sel), 32'd0);
    RESET = 1'b1;
    req_h = 4'b0101;
    serve(2'd0);

    // INIT mid-offer of device 2 (pointer at 0); INIT must rewind it to NREQ-1
    wait_offer(2'd2);
    req_h     = 4'b0101;
    init_in_h = 1'b1;
    tick();
    chk("init_intvec", 32'(intvec), 32'h01);
    chk("init_busy", 32'(busy_h), 32'd0);
    chk("init_sel", 32'(sel), 32'd0);
    chk("init_ack", 32'(ack_h), 32'd0);
    init_in_h = 1'b0;
    tick();
    chk("init_first_sel", 32'(sel), 32'd0);
    chk("init_first_vec", 32'(intvec), 32'h10);
    complete(2'd0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
